// File: rtl/multi_digit_scroll_driver_if.sv
// Character-write port, display mode/DP controls and the multiplexed 7-segment
// drive lines of the scroll driver.
interface multi_digit_scroll_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_DEPTH  = 16
);
  localparam int AW = $clog2(MSG_DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  mode;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output wr_en, wr_addr, wr_data, mode, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, mode, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/multi_digit_scroll_driver.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS digits from a small hex
// character memory, optionally scrolling the message one character per step.
module multi_digit_scroll_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int MSG_DEPTH     = 16,
  parameter int REFRESH_DIV   = 4096,
  parameter int BLANK_CYCLES  = 64,
  parameter int SCROLL_FRAMES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  multi_digit_scroll_driver_if.slave  bus
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [SW-1:0] SC_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_SC = SW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(SCROLL_FRAMES - 1);
  localparam logic [AW-1:0] ADDR_OFS = AW'(NUM_DIGITS - 1);

  logic [SW-1:0]         r_sc;
  logic [IW-1:0]         r_idx;
  logic [AW-1:0]         r_base;
  logic [FW-1:0]         r_frame;
  logic [3:0]            r_mem [MSG_DEPTH];
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [SW-1:0]         w_sc_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [AW-1:0]         w_rd_addr;

  function automatic logic [6:0] f_decode(input logic [3:0] ch);
    case (ch)
      4'h0: f_decode = 7'b0000001;
      4'h1: f_decode = 7'b1001111;
      4'h2: f_decode = 7'b0010010;
      4'h3: f_decode = 7'b0000110;
      4'h4: f_decode = 7'b1001100;
      4'h5: f_decode = 7'b0100100;
      4'h6: f_decode = 7'b0100000;
      4'h7: f_decode = 7'b0001111;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0000100;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b1100000;
      4'hC: f_decode = 7'b0110001;
      4'hD: f_decode = 7'b1000010;
      4'hE: f_decode = 7'b0110000;
      default: f_decode = 7'b0111000;
    endcase
  endfunction

  // Anodes are registered from the next scan position so that an[] lines up
  // with the (sc, idx) values of the cycle in which it is visible.
  always_comb begin
    w_slot_end  = (r_sc == SC_LAST);
    w_frame_end = w_slot_end && (r_idx == '0);
    w_sc_nxt    = w_slot_end ? '0 : r_sc + SW'(1);
    w_idx_nxt   = r_idx;
    if (w_slot_end) w_idx_nxt = (r_idx == '0) ? IDX_LAST : r_idx - IW'(1);
    w_an_nxt = '1;
    if (w_sc_nxt >= BLANK_SC) w_an_nxt[w_idx_nxt] = 1'b0;
    w_rd_addr = r_base + ADDR_OFS - AW'(r_idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sc    <= '0;
      r_idx   <= IDX_LAST;
      r_base  <= '0;
      r_frame <= '0;
      r_an    <= '1;
      r_seg   <= '1;
      r_dp    <= 1'b1;
      // NOTE: the message store must read back as zeros after reset, so it is
      // built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < MSG_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_sc  <= w_sc_nxt;
      r_idx <= w_idx_nxt;
      r_an  <= w_an_nxt;
      // NOTE: non-blocking updates make a same-edge write invisible to this
      // fetch; the stored value shows up on the next fetch of that address.
      if (r_sc == '0) begin
        r_seg <= f_decode(r_mem[w_rd_addr]);
        r_dp  <= ~bus.dp_mask[r_idx];
      end
      if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;

      if (!bus.mode) begin
        r_base  <= '0;
        r_frame <= '0;
      end else if (w_frame_end) begin
        if (r_frame == FR_LAST) begin
          r_frame <= '0;
          r_base  <= r_base + AW'(1);
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
endmodule

// File: tb/tb_multi_digit_scroll_driver.sv
// Bench for multi_digit_scroll_driver: a cycle-count based reference model
// checks every cycle, plus a glyph table and hand-written corner sequences.
module tb_multi_digit_scroll_driver;
  localparam int ND = 4;
  localparam int MD = 8;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int SF = 2;

  typedef struct {
    logic [3:0] ch;
    logic [6:0] seg;
  } glyph_vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_digit_scroll_driver_if #(.NUM_DIGITS(ND), .MSG_DEPTH(MD)) bus ();

  multi_digit_scroll_driver #(
    .NUM_DIGITS(ND), .MSG_DEPTH(MD), .REFRESH_DIV(RD),
    .BLANK_CYCLES(BC), .SCROLL_FRAMES(SF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  glyph_vec_t    tbl [16];
  int            n_cmp = 0;
  int            n_err = 0;

  // Reference model: everything derived from the cycle count since reset.
  logic [3:0]    m_mem [MD];
  int            m_t;
  int            m_fs;
  logic [ND-1:0] m_an;
  logic [6:0]    m_seg;
  logic          m_dp;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int slot_idx(input int t);
    return ND - 1 - ((t / RD) % ND);
  endfunction

  task automatic model_edge();
    int sc;
    int idx;
    int base;
    if (!reset) begin
      for (int i = 0; i < MD; i++) m_mem[i] = '0;
      m_t = 0; m_fs = 0; m_an = '1; m_seg = '1; m_dp = 1'b1;
      return;
    end
    sc  = m_t % RD;
    idx = slot_idx(m_t);
    if (sc == 0) begin
      base  = (m_fs / SF) % MD;
      m_seg = tbl[m_mem[(base + ND - 1 - idx) % MD]].seg;
      m_dp  = ~bus.dp_mask[idx];
    end
    if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
    if (bus.mode) begin
      if ((m_t + 1) % (RD * ND) == 0) m_fs++;
    end else begin
      m_fs = 0;
    end
    m_t++;
    m_an = '1;
    if ((m_t % RD) >= BC) m_an[slot_idx(m_t)] = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("an",  16'(bus.an),  16'(m_an));
    check("seg", 16'(bus.seg), 16'(m_seg));
    check("dp",  16'(bus.dp),  16'(m_dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tbl[0]  = '{4'h0, 7'b0000001}; tbl[1]  = '{4'h1, 7'b1001111};
    tbl[2]  = '{4'h2, 7'b0010010}; tbl[3]  = '{4'h3, 7'b0000110};
    tbl[4]  = '{4'h4, 7'b1001100}; tbl[5]  = '{4'h5, 7'b0100100};
    tbl[6]  = '{4'h6, 7'b0100000}; tbl[7]  = '{4'h7, 7'b0001111};
    tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0000100};
    tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b1100000};
    tbl[12] = '{4'hC, 7'b0110001}; tbl[13] = '{4'hD, 7'b1000010};
    tbl[14] = '{4'hE, 7'b0110000}; tbl[15] = '{4'hF, 7'b0111000};

    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mode = 1'b0; bus.dp_mask = '0;
    step();
    check("rst_an",  16'(bus.an),  16'h000F);
    check("rst_seg", 16'(bus.seg), 16'h007F);
    check("rst_dp",  16'(bus.dp),  16'h0001);
    reset = 1'b1;

    // Idle: blank glyph "0"; then a write landing on the fetch edge of addr 1.
    while (m_t != 8) step();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'h5;
    step();
    bus.wr_en = 1'b0;
    while (m_t != 12) step();
    check("same_edge_old", 16'(bus.seg), 16'(tbl[0].seg));
    check("same_edge_an",  16'(bus.an),  16'h000B);
    while (m_t != 44) step();
    check("same_edge_new", 16'(bus.seg), 16'(tbl[5].seg));

    // Table-driven glyph sweep, four characters per frame.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < ND; k++) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'(k); bus.wr_data = tbl[4*g + k].ch;
        step();
      end
      bus.wr_en = 1'b0;
      run(RD * ND);
      for (int i = 0; i < RD * ND; i++) begin
        step();
        if (m_t % RD == 4)
          check("glyph", 16'(bus.seg), 16'(tbl[4*g + (m_t / RD) % ND].seg));
      end
    end

    // Decimal point on digit 2 only.
    bus.dp_mask = 4'b0100;
    run(RD * ND);
    for (int i = 0; i < RD * ND; i++) begin
      step();
      if (m_t % RD == 4)
        check("dp_mask", 16'(bus.dp), (slot_idx(m_t) == 2) ? 16'h0000 : 16'h0001);
    end

    // Reset pulse mid-slot: outputs off, scan restarts at digit 3, memory zero.
    while (m_t % RD != 5) step();
    reset = 1'b0;
    step();
    check("mid_rst_an",  16'(bus.an),  16'h000F);
    check("mid_rst_seg", 16'(bus.seg), 16'h007F);
    check("mid_rst_dp",  16'(bus.dp),  16'h0001);
    reset = 1'b1;
    bus.dp_mask = '0;
    while (m_t != 4) step();
    check("post_rst_an",  16'(bus.an),  16'h0007);
    check("post_rst_seg", 16'(bus.seg), 16'(tbl[0].seg));

    // Scroll through 1..8 with wrap back around to 1234.
    for (int i = 0; i < MD; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = 4'(i + 1);
      step();
    end
    bus.wr_en = 1'b0;
    bus.mode  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      while (m_t != 68 + 64 * k) step();
      check("scroll_d3", 16'(bus.seg), 16'(tbl[((1 + k) % MD) + 1].seg));
    end
    bus.mode = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 3'($urandom_range(0, MD - 1));
      bus.wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0)  bus.dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
      reset = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
